motor_ramp_ctrl: RTL and testbench

Per-wheel speed-command sequencer that sits between the chassis motion logic and the PWM/H-bridge driver. It accepts signed speed targets over a valid/ready handshake and slews the output duty toward the target at a programmable rate. On every direction reversal it inserts a zero-duty dead interval so the H-bridge never flips while loaded. It provides an emergency-stop override. Output `duty` is sign-extended by the instantiating level onto the driver's 40-bit signed duty input.

---
 rtl/motor_pkg.sv | 39 +++
 rtl/motor_tick_gen.sv | 33 +++
 rtl/motor_ramp_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types, defaults and helpers for the motor ramp controller
//
// Purpose: state encoding, default widths, and the two small arithmetic helpers
// (symmetric saturation and sign comparison) used by motor_ramp_ctrl.
// Ports: none (package).

package motor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RAMP  = 2'd1,
      ST_DEAD  = 2'd2,
      ST_ESTOP = 2'd3
   } motor_state_t;

   localparam int DW_DEFAULT     = 24;
   localparam int STEP_W_DEFAULT = 16;

   // Clamp v into the symmetric range +/-(2^(w-1)-1). The only value of a
   // w-bit signed word that falls outside it is the most negative one.
   function automatic logic signed [63:0] sat_sym(input logic signed [63:0] v,
                                                  input int w);
      logic signed [63:0] lim;
      lim = (64'sd1 <<< (w - 1)) - 64'sd1;
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      else
         return v;
   endfunction

   // True when a and b lie on opposite sides of zero (zero counts as positive).
   function automatic logic sign_differs(input logic signed [63:0] a,
                                         input logic signed [63:0] b);
      return (a < 0) != (b < 0);
   endfunction

endpackage

// File: rtl/motor_tick_gen.sv
// rtl/motor_tick_gen.sv - free-running prescaler producing a one-cycle tick
//
// Purpose: modulo-TICK_DIV counter; tick is high on the cycle the counter
// equals TICK_DIV-1. Reusable by other chassis timing blocks.
// Ports:
//   clk   in  1  system clock
//   reset in  1  synchronous active-high reset (counter -> 0)
//   tick  out 1  one-cycle strobe every TICK_DIV clocks

module motor_tick_gen #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// rtl/motor_ramp_ctrl.sv - slew-limited signed duty sequencer with dead time and estop
//
// Purpose: accepts signed speed targets, slews duty toward them by at most
// `step` per tick, inserts a zero-duty dead interval on every return to zero
// from nonzero, and overrides everything on estop.
// Optional feature: define MOTOR_WDOG_EN to enable the command watchdog.
// Ports:
//   clk       in  1       system clock
//   reset     in  1       synchronous active-high reset
//   cmd_valid in  1       speed command presented
//   cmd_ready out 1       command can be accepted (combinational from estop)
//   cmd_speed in  DW      signed target
//   step      in  STEP_W  max |delta duty| per tick
//   estop     in  1       emergency stop, level-sensitive
//   duty      out DW      registered signed duty
//   at_target out 1       duty == target and not in DEAD
//   state_o   out 2       current FSM state
//   fault     out 1       watchdog expired, sticky until next accept

module motor_ramp_ctrl
   import motor_pkg::*;
#(
   parameter int DW       = DW_DEFAULT,
   parameter int STEP_W   = STEP_W_DEFAULT,
   parameter int TICK_DIV = 1000,
   parameter int DEAD_CYC = 50000,
   parameter int WDOG_CYC = 5000000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic signed [DW-1:0] cmd_speed,
   input  logic [STEP_W-1:0]    step,
   input  logic                 estop,
   output logic signed [DW-1:0] duty,
   output logic                 at_target,
   output logic [1:0]           state_o,
   output logic                 fault
);

   localparam int DCW = $clog2(DEAD_CYC + 1);

   if (TICK_DIV < 2 || DEAD_CYC < 1 || WDOG_CYC < 1) begin : g_bad_cfg
      $error("motor_ramp_ctrl: invalid timing parameters");
   end

   motor_state_t          state, state_n;
   logic signed [DW-1:0]  target, target_n, duty_n;
   logic [DCW-1:0]        dead_cnt, dead_n;
   logic                  at_target_n;
   logic                  tick;
   logic                  accept;
   logic signed [DW-1:0]  cmd_clamped;
   logic signed [DW-1:0]  goal;
   logic [DW:0]           diff;
   logic [DW-1:0]         mag, step_d, delta;
   logic signed [DW-1:0]  ramp_duty;

   motor_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign cmd_ready   = !estop && (state != ST_ESTOP);
   assign accept      = cmd_valid && cmd_ready;
   assign cmd_clamped = DW'(sat_sym(64'(cmd_speed), DW));
   assign state_o     = state;

   // Any move that would cross zero first heads to zero, so a reversal
   // always passes through DEAD.
   assign goal = ((duty != '0) && ((target == '0) || sign_differs(64'(target), 64'(duty))))
                 ? '0 : target;

   // One extra bit keeps goal - duty exact for any pair of in-range values.
   assign diff      = {goal[DW-1], goal} - {duty[DW-1], duty};
   assign mag       = diff[DW] ? DW'(-diff) : DW'(diff);
   assign step_d    = DW'(step);
   assign delta     = (step_d < mag) ? step_d : mag;
   assign ramp_duty = diff[DW] ? (duty - delta) : (duty + delta);

`ifdef MOTOR_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);
   logic [WW-1:0] wdog_cnt, wdog_n;
   logic          fault_r, fault_n;
   assign fault = fault_r;
`else
   assign fault = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      duty_n   = duty;
      target_n = target;
      dead_n   = dead_cnt;

`ifdef MOTOR_WDOG_EN
      wdog_n  = wdog_cnt;
      fault_n = fault_r;
      if (accept) begin
         wdog_n  = '0;
         fault_n = 1'b0;
      end else if (wdog_cnt != WW'(WDOG_CYC)) begin
         wdog_n = wdog_cnt + WW'(1);
         if (wdog_cnt == WW'(WDOG_CYC - 1)) begin
            fault_n  = 1'b1;
            target_n = '0;
         end
      end
`endif

      if (estop) begin
         state_n  = ST_ESTOP;
         duty_n   = '0;
         target_n = '0;
         dead_n   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  target_n = cmd_clamped;
                  if (cmd_clamped != '0)
                     state_n = ST_RAMP;
               end
            end
            ST_RAMP: begin
               if (accept)
                  target_n = cmd_clamped;
               if (tick)
                  duty_n = ramp_duty;
               if (tick && (duty != '0) && (ramp_duty == '0)) begin
                  state_n = ST_DEAD;
                  dead_n  = '0;
               end else if ((duty == '0) && (target_n == '0)) begin
                  state_n = ST_IDLE;
               end
            end
            ST_DEAD: begin
               if (accept)
                  target_n = cmd_clamped;
               if (dead_cnt == DCW'(DEAD_CYC - 1)) begin
                  dead_n  = '0;
                  state_n = (target_n != '0) ? ST_RAMP : ST_IDLE;
               end else begin
                  dead_n = dead_cnt + DCW'(1);
               end
            end
            ST_ESTOP: begin
               // estop just released: restart the dead interval
               state_n = ST_DEAD;
               dead_n  = '0;
               duty_n  = '0;
            end
         endcase
      end

      at_target_n = (duty_n == target_n) && (state_n != ST_DEAD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         duty      <= '0;
         target    <= '0;
         dead_cnt  <= '0;
         at_target <= 1'b1;
`ifdef MOTOR_WDOG_EN
         wdog_cnt  <= '0;
         fault_r   <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         duty      <= duty_n;
         target    <= target_n;
         dead_cnt  <= dead_n;
         at_target <= at_target_n;
`ifdef MOTOR_WDOG_EN
         wdog_cnt  <= wdog_n;
         fault_r   <= fault_n;
`endif
      end
   end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb/tb_motor_ramp_ctrl.sv - directed self-checking bench for motor_ramp_ctrl

module tb_motor_ramp_ctrl;

   localparam int DW = 24;
   localparam int SW = 16;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 cmd_valid = 1'b0;
   logic                 estop = 1'b0;
   logic signed [DW-1:0] cmd_speed = '0;
   logic [SW-1:0]        step = 16'd100;
   logic                 cmd_ready;
   logic signed [DW-1:0] duty;
   logic                 at_target;
   logic [1:0]           state_o;
   logic                 fault;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   motor_ramp_ctrl #(
      .DW(DW), .STEP_W(SW), .TICK_DIV(4), .DEAD_CYC(8), .WDOG_CYC(40)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_speed (cmd_speed),
      .step      (step),
      .estop     (estop),
      .duty      (duty),
      .at_target (at_target),
      .state_o   (state_o),
      .fault     (fault)
   );

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cmd_valid = 1'b0;
      estop = 1'b0;
      repeat (2) step_clk();
      reset = 1'b0;
   endtask

   task automatic send_cmd(input int v);
      cmd_speed = DW'(v);
      cmd_valid = 1'b1;
      step_clk();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_change(output int v, output int cyc);
      logic signed [DW-1:0] prev;
      prev = duty;
      cyc = 0;
      do begin
         step_clk();
         cyc++;
      end while (duty === prev && cyc < 40);
      v = int'(duty);
      checks++;
      if (duty === prev) begin
         failures++;
         $display("FAIL wait_change: duty stuck at %0d after %0d cycles", int'(duty), cyc);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (duty !== '0) begin failures++; $display("FAIL reset_duty: got %0d want 0", int'(duty)); end
      checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state_o); end
      checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL reset_at_target: got %b want 1", at_target); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b want 0", fault); end
   endtask

   task automatic test_ramp_up();
      int exp[4] = '{100, 200, 300, 350};
      int v, cyc;
      step = 16'd100;
      send_cmd(350);
      checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL ramp_state: got %0d want 1", state_o); end
      for (int i = 0; i < 4; i++) begin
         wait_change(v, cyc);
         checks++; if (v !== exp[i]) begin failures++; $display("FAIL ramp_duty[%0d]: got %0d want %0d", i, v, exp[i]); end
         if (i > 0) begin
            checks++; if (cyc !== 4) begin failures++; $display("FAIL ramp_period[%0d]: got %0d want 4", i, cyc); end
         end
         if (i == 0) begin
            checks++; if (at_target !== 1'b0) begin failures++; $display("FAIL ramp_at_target_mid: got %b want 0", at_target); end
         end
      end
      checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL ramp_at_target: got %b want 1", at_target); end
      checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL ramp_state_end: got %0d want 1", state_o); end
   endtask

   task automatic test_reversal();
      int exp[4] = '{250, 150, 50, 0};
      int v, cyc, n;
      logic bad;
      send_cmd(-150);
      for (int i = 0; i < 4; i++) begin
         wait_change(v, cyc);
         checks++; if (v !== exp[i]) begin failures++; $display("FAIL rev_down[%0d]: got %0d want %0d", i, v, exp[i]); end
      end
      checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL rev_dead_state: got %0d want 2", state_o); end
      n = 0;
      bad = 1'b0;
      while (state_o == 2'd2 && n < 30) begin
         if (duty !== '0) bad = 1'b1;
         n++;
         step_clk();
      end
      checks++; if (n !== 8) begin failures++; $display("FAIL rev_dead_len: got %0d want 8", n); end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rev_dead_duty: got nonzero want 0"); end
      checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL rev_after_dead: got %0d want 1", state_o); end
      wait_change(v, cyc);
      checks++; if (v !== -100) begin failures++; $display("FAIL rev_up0: got %0d want -100", v); end
      wait_change(v, cyc);
      checks++; if (v !== -150) begin failures++; $display("FAIL rev_up1: got %0d want -150", v); end
      checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL rev_at_target: got %b want 1", at_target); end
   endtask

   task automatic test_estop();
      int v, cyc, n;
      do_reset();
      send_cmd(350);
      wait_change(v, cyc);
      wait_change(v, cyc);
      estop = 1'b1;
      cmd_valid = 1'b1;
      cmd_speed = DW'(500);
      #1;
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL estop_ready: got %b want 0", cmd_ready); end
      step_clk();
      cmd_valid = 1'b0;
      checks++; if (duty !== '0) begin failures++; $display("FAIL estop_duty: got %0d want 0", int'(duty)); end
      checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL estop_state: got %0d want 3", state_o); end
      repeat (3) step_clk();
      checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL estop_hold: got %0d want 3", state_o); end
      estop = 1'b0;
      step_clk();
      checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL estop_to_dead: got %0d want 2", state_o); end
      n = 0;
      while (state_o == 2'd2 && n < 30) begin
         n++;
         step_clk();
      end
      checks++; if (n !== 8) begin failures++; $display("FAIL estop_dead_len: got %0d want 8", n); end
      checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL estop_idle: got %0d want 0", state_o); end
      checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL estop_at_target: got %b want 1", at_target); end
      repeat (8) step_clk();
      checks++; if (duty !== '0) begin failures++; $display("FAIL estop_cmd_ignored: got %0d want 0", int'(duty)); end
   endtask

   task automatic test_clamp_step0();
      logic bad;
      int n;
      do_reset();
      step = 16'd0;
      send_cmd(-8388608);
      checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL clamp_state: got %0d want 1", state_o); end
      bad = 1'b0;
      repeat (32) begin
         step_clk();
         if (duty !== '0 || at_target !== 1'b0) bad = 1'b1;
      end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL step0_hold: duty=%0d at_target=%b want 0/0", int'(duty), at_target); end
`ifndef MOTOR_WDOG_EN
      step = 16'hFFFF;
      n = 0;
      while (at_target !== 1'b1 && n < 800) begin
         step_clk();
         n++;
      end
      checks++; if (int'(duty) !== -8388607) begin failures++; $display("FAIL clamp_target: got %0d want -8388607", int'(duty)); end
      checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL clamp_at_target: got %b want 1", at_target); end
`endif
      step = 16'd100;
   endtask

   task automatic test_back_to_back();
      int v, cyc;
      do_reset();
      send_cmd(350);
      send_cmd(120);
      wait_change(v, cyc);
      checks++; if (v !== 100) begin failures++; $display("FAIL b2b_first: got %0d want 100", v); end
      wait_change(v, cyc);
      checks++; if (v !== 120) begin failures++; $display("FAIL b2b_second: got %0d want 120", v); end
      checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL b2b_at_target: got %b want 1", at_target); end
   endtask

   task automatic test_reset_dead();
      int v, cyc;
      do_reset();
      send_cmd(100);
      wait_change(v, cyc);
      send_cmd(0);
      wait_change(v, cyc);
      checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL rstdead_in_dead: got %0d want 2", state_o); end
      repeat (3) step_clk();
      reset = 1'b1;
      step_clk();
      checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL rstdead_state: got %0d want 0", state_o); end
      checks++; if (duty !== '0) begin failures++; $display("FAIL rstdead_duty: got %0d want 0", int'(duty)); end
      checks++; if (at_target !== 1'b1) begin failures++; $display("FAIL rstdead_at_target: got %b want 1", at_target); end
      reset = 1'b0;
      send_cmd(200);
      checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL rstdead_ramp: got %0d want 1", state_o); end
      wait_change(v, cyc);
      checks++; if (v !== 100) begin failures++; $display("FAIL rstdead_duty1: got %0d want 100", v); end
      checks++; if (cyc > 4) begin failures++; $display("FAIL rstdead_latency: got %0d want <=4", cyc); end
   endtask

`ifdef MOTOR_WDOG_EN
   task automatic test_watchdog();
      int v, cyc, n;
      do_reset();
      send_cmd(200);
      n = 0;
      while (fault !== 1'b1 && n < 60) begin
         step_clk();
         n++;
      end
      checks++; if (n !== 40) begin failures++; $display("FAIL wdog_time: got %0d want 40", n); end
      checks++; if (int'(duty) !== 200) begin failures++; $display("FAIL wdog_duty_at_fault: got %0d want 200", int'(duty)); end
      wait_change(v, cyc);
      checks++; if (v !== 100) begin failures++; $display("FAIL wdog_down0: got %0d want 100", v); end
      wait_change(v, cyc);
      checks++; if (v !== 0) begin failures++; $display("FAIL wdog_down1: got %0d want 0", v); end
      checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL wdog_dead: got %0d want 2", state_o); end
      checks++; if (fault !== 1'b1) begin failures++; $display("FAIL wdog_sticky: got %b want 1", fault); end
      send_cmd(50);
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL wdog_clear: got %b want 0", fault); end
   endtask
`else
   task automatic test_watchdog();
      do_reset();
      repeat (50) step_clk();
      checks++; if (fault !== 1'b0) begin failures++; $display("FAIL wdog_off_fault: got %b want 0", fault); end
   endtask
`endif

   initial begin
      test_reset();
      test_ramp_up();
      test_reversal();
      test_estop();
      test_clamp_step0();
      test_back_to_back();
      test_reset_dead();
      test_watchdog();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
